station_download_arbiter: RTL and testbench
===========================================

Name: station_download_arbiter

Overview:
- Base-station scheduler that shares the single download link between N_CAM camera units.
- Watches each camera's ready-to-download level and grants the link to one camera at a time, round-robin.
- Issues the one-cycle Download pulse, tracks the transfer until that camera's buffer reaches 0, then releases the link.
- If a granted camera never starts its transfer within a time limit, a watchdog issues Flush to it instead.

Parameters:
- N_CAM, 2, number of camera units sharing the link (2..8).
- TIMEOUT, 16, cycles allowed between download pulse and camera deasserting ready before Flush is issued (>=2).
- IDW, $clog2(N_CAM), width of owner index.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; clears all state on the next rising clk edge.
- ready_req  in  N_CAM  per camera, high while that camera is ready to download.
- buf_empty  in  N_CAM  per camera, high when that camera's sample count is 0.
- download_pulse  out  N_CAM  one-hot, one-cycle Download request to the owner.
- flush_pulse  out  N_CAM  one-hot, one-cycle Flush request to the owner on timeout.
- owner  out  IDW  index of the camera holding the link; valid only when owner_valid is high.
- owner_valid  out  1  high from GRANT through DONE.
- timeout_evt  out  1  one-cycle pulse, coincident with flush_pulse.
- last_xfer_len  out  16  optional-feature output; see Optional Feature.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, wd_cnt=0; all outputs 0.
- States: IDLE, GRANT, WAIT_START, XFER, DONE.
- IDLE:
  - Scan ready_req starting at rr_ptr, incrementing and wrapping modulo N_CAM.
  - First set bit becomes owner; next state is GRANT.
  - No bits set: stay in IDLE.
  - Selection is combinational on the current inputs; the owner register loads at the edge.
- GRANT (exactly 1 cycle):
  - download_pulse[owner]=1, owner_valid=1, wd_cnt cleared.
  - Next state: WAIT_START.
- WAIT_START:
  - ready_req[owner]==0: next state XFER (the camera has accepted and left its ready states).
  - Else wd_cnt increments. When wd_cnt==TIMEOUT-1: flush_pulse[owner]=1 and timeout_evt=1 for that cycle, then go to XFER.
  - The flush check takes priority only if ready_req[owner] is still 1 on that cycle.
- XFER:
  - Stay until buf_empty[owner]==1, then go to DONE.
  - If buf_empty[owner] is already 1 on entry, leave on the next edge.
  - No watchdog in XFER.
- DONE (exactly 1 cycle):
  - owner_valid=1; rr_ptr <= (owner+1) mod N_CAM.
  - Next state: IDLE; the new arbitration begins the following cycle.
- Fairness: a requester waits at most N_CAM-1 complete transfers.
- Requests from non-owners during a transfer are ignored; they are level inputs, so they are re-seen in IDLE.
- Owner's ready_req dropping in GRANT: the deassert is sampled in WAIT_START, which then exits in 1 cycle.
- Reset mid-operation: any pulse in flight is truncated, and no Flush is issued.
- download_pulse and flush_pulse are never high in the same cycle.
- Both pulses are registered (glitch-free).

Optional Feature:
- Macro: STATION_XFER_STATS_EN.
- Defined:
  - A 16-bit counter clears in GRANT and increments every cycle in WAIT_START and XFER, saturating at 16'hFFFF.
  - last_xfer_len loads the counter value on entry to DONE and holds it until the next DONE.
  - last_xfer_len resets to 0.
- Undefined: last_xfer_len is tied to 0 and no counter logic is built.

Decomposition:
- Package station_pkg:
  - Typedef arb_state_t enum {IDLE, GRANT, WAIT_START, XFER, DONE}.
  - Constant STATION_DEFAULT_TIMEOUT=16.
  - Function rr_pick(req, ptr) returning the index and a found flag.
- Sub-module rr_picker: purely combinational rotate-and-priority-encode over N_CAM.
  - Instantiated once; kept separate so it can be unit-tested alone.

Test Plan:
- Reset held 5 cycles with ready_req=2'b11 -> all outputs 0, no pulses; after release, GRANT to owner 0, download_pulse=2'b01 for exactly 1 cycle.
- Single camera 1: ready_req[1] rises, drops 2 cycles after the pulse; buf_empty[1] rises 20 cycles later -> owner=1, states GRANT→WAIT_START→XFER→DONE→IDLE; with macro defined, last_xfer_len=22.
- Both ready continuously, each transfer completes -> grants alternate 0,1,0,1; owner 0 cannot be granted twice in a row.
- Camera 0 granted but ready_req[0] held high (TIMEOUT=16) -> flush_pulse=2'b01 and timeout_evt on the 16th WAIT_START cycle; XFER entered; releases once buf_empty[0]=1.
- buf_empty[owner] already 1 when ready_req drops -> XFER lasts 1 cycle, then DONE, then IDLE.
- Reset asserted mid-XFER -> next edge returns to IDLE with owner_valid=0 and rr_ptr=0; the next grant goes to the lowest-index ready camera.

Source files
------------

// File: rtl/station_pkg.sv
// Shared types and helpers for the station download arbiter.
// Provides the arbiter state encoding, the default watchdog limit and the round-robin pick function.
package station_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GRANT,
      WAIT_START,
      XFER,
      DONE
   } arb_state_t;

   localparam int STATION_DEFAULT_TIMEOUT = 16;
   localparam int RR_MAX_CAM = 8;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } rr_pick_t;

   // Lowest rotated offset wins, so the loop walks from the far end down to ptr.
   function automatic rr_pick_t rr_pick(input logic [RR_MAX_CAM-1:0] req,
                                        input logic [2:0]            ptr,
                                        input int                    n);
      rr_pick_t   res;
      logic [2:0] pos;
      res = '0;
      for (int k = RR_MAX_CAM - 1; k >= 0; k--) begin
         if (k < n) begin
            pos = 3'((int'(ptr) + k) % n);
            if (req[pos]) begin
               res.found = 1'b1;
               res.idx   = pos;
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/station_download_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping over N_CAM.
// Standalone so it can be exercised on its own.
module rr_picker
   import station_pkg::*;
#(
   parameter int N_CAM = 2,
   parameter int IDW   = $clog2(N_CAM)
) (
   input  logic [N_CAM-1:0] req_i,
   input  logic [IDW-1:0]   ptr_i,
   output logic             found_o,
   output logic [IDW-1:0]   idx_o
);

   logic [RR_MAX_CAM-1:0] req_pad;
   logic [2:0]            ptr_pad;
   rr_pick_t              pick;

   genvar gi;
   generate
      for (gi = 0; gi < RR_MAX_CAM; gi++) begin : g_pad
         if (gi < N_CAM) begin : g_in
            assign req_pad[gi] = req_i[gi];
         end else begin : g_zero
            assign req_pad[gi] = 1'b0;
         end
      end
   endgenerate

   assign ptr_pad = 3'(ptr_i);
   assign pick    = rr_pick(req_pad, ptr_pad, N_CAM);
   assign found_o = pick.found;
   assign idx_o   = IDW'(pick.idx);

endmodule

// File: rtl/station_download_arbiter.sv
// Round-robin download-link arbiter with start watchdog for N_CAM camera units.
// Optional transfer-length statistics are built when STATION_XFER_STATS_EN is defined.
module station_download_arbiter
   import station_pkg::*;
#(
   parameter int N_CAM   = 2,
   parameter int TIMEOUT = STATION_DEFAULT_TIMEOUT,
   parameter int IDW     = $clog2(N_CAM)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_CAM-1:0] ready_req,
   input  logic [N_CAM-1:0] buf_empty,
   output logic [N_CAM-1:0] download_pulse,
   output logic [N_CAM-1:0] flush_pulse,
   output logic [IDW-1:0]   owner,
   output logic             owner_valid,
   output logic             timeout_evt,
   output logic [15:0]      last_xfer_len
);

   localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
   localparam logic [WDW-1:0] WD_PRE  = WDW'(TIMEOUT - 2);

   arb_state_t       state_q, state_d;
   logic [IDW-1:0]   owner_q, owner_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [WDW-1:0]   wd_cnt_q, wd_cnt_d;
   logic [N_CAM-1:0] dl_q, dl_d;
   logic [N_CAM-1:0] fl_q, fl_d;
   logic             ov_q, ov_d;
   logic             to_q, to_d;

   logic             pick_found;
   logic [IDW-1:0]   pick_idx;
   logic             owner_ready;
   logic             owner_empty;

   rr_picker #(
      .N_CAM (N_CAM),
      .IDW   (IDW)
   ) u_picker (
      .req_i   (ready_req),
      .ptr_i   (rr_ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   assign owner_ready = ready_req[owner_q];
   assign owner_empty = buf_empty[owner_q];

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      wd_cnt_d = wd_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               owner_d = pick_idx;
               state_d = GRANT;
            end
         end
         GRANT: begin
            wd_cnt_d = '0;
            state_d  = WAIT_START;
         end
         WAIT_START: begin
            if (!owner_ready) begin
               state_d = XFER;
            end else begin
               wd_cnt_d = wd_cnt_q + 1'b1;
               if (wd_cnt_q == WD_LAST) begin
                  state_d = XFER;
               end
            end
         end
         XFER: begin
            if (owner_empty) begin
               state_d = DONE;
            end
         end
         DONE: begin
            rr_ptr_d = (owner_q == IDW'(N_CAM - 1)) ? '0 : owner_q + 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Pulses are registered, so each is decided one cycle ahead: the flush lands
   // on the cycle where wd_cnt reaches TIMEOUT-1.
   always_comb begin
      dl_d = '0;
      fl_d = '0;
      if (state_d == GRANT) begin
         dl_d[owner_d] = 1'b1;
      end
      to_d = (state_q == WAIT_START) && owner_ready &&
             (wd_cnt_q == WD_PRE) && (state_d == WAIT_START);
      if (to_d) begin
         fl_d[owner_q] = 1'b1;
      end
      ov_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         wd_cnt_q <= '0;
         dl_q     <= '0;
         fl_q     <= '0;
         ov_q     <= 1'b0;
         to_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         wd_cnt_q <= wd_cnt_d;
         dl_q     <= dl_d;
         fl_q     <= fl_d;
         ov_q     <= ov_d;
         to_q     <= to_d;
      end
   end

   assign download_pulse = dl_q;
   assign flush_pulse    = fl_q;
   assign owner          = owner_q;
   assign owner_valid    = ov_q;
   assign timeout_evt    = to_q;

`ifdef STATION_XFER_STATS_EN
   logic [15:0] len_cnt_q, len_cnt_d;
   logic [15:0] last_len_q, last_len_d;

   // The captured length includes the cycle in which the transfer completes.
   always_comb begin
      len_cnt_d  = len_cnt_q;
      last_len_d = last_len_q;
      if (state_q == GRANT) begin
         len_cnt_d = '0;
      end else if ((state_q == WAIT_START || state_q == XFER) && len_cnt_q != 16'hFFFF) begin
         len_cnt_d = len_cnt_q + 16'd1;
      end
      if (state_q != DONE && state_d == DONE) begin
         last_len_d = len_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         len_cnt_q  <= '0;
         last_len_q <= '0;
      end else begin
         len_cnt_q  <= len_cnt_d;
         last_len_q <= last_len_d;
      end
   end

   assign last_xfer_len = last_len_q;
`else
   assign last_xfer_len = '0;
`endif

endmodule

// File: tb/tb_station_download_arbiter.sv
// Directed bench for station_download_arbiter (N_CAM=2, TIMEOUT=16).
// Cycle table for arbitration/reset plus hand sequences for watchdog and transfer length.
module tb_station_download_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  ready_req;
   logic [1:0]  buf_empty;
   logic [1:0]  download_pulse;
   logic [1:0]  flush_pulse;
   logic [0:0]  owner;
   logic        owner_valid;
   logic        timeout_evt;
   logic [15:0] last_xfer_len;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef STATION_XFER_STATS_EN
   localparam logic [15:0] EXP_LEN = 16'd22;
`else
   localparam logic [15:0] EXP_LEN = 16'd0;
`endif

   always #5 clk = ~clk;

   station_download_arbiter #(
      .N_CAM   (2),
      .TIMEOUT (16)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .ready_req      (ready_req),
      .buf_empty      (buf_empty),
      .download_pulse (download_pulse),
      .flush_pulse    (flush_pulse),
      .owner          (owner),
      .owner_valid    (owner_valid),
      .timeout_evt    (timeout_evt),
      .last_xfer_len  (last_xfer_len)
   );

   typedef struct {
      logic       rst;
      logic [1:0] rdy;
      logic [1:0] be;
      logic [1:0] dl;
      logic [1:0] fl;
      logic       ov;
      logic       own;
      logic       to;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic rst, input logic [1:0] rdy, input logic [1:0] be,
                      input logic [1:0] dl, input logic [1:0] fl,
                      input logic ov, input logic own, input logic to);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.be = be;
      v.dl = dl; v.fl = fl; v.ov = ov; v.own = own; v.to = to;
      vq.push_back(v);
   endtask

   task automatic step(input logic rst, input logic [1:0] rdy, input logic [1:0] be);
      @(negedge clk);
      reset     = rst;
      ready_req = rdy;
      buf_empty = be;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   initial begin
      reset     = 1'b1;
      ready_req = 2'b11;
      buf_empty = 2'b00;

      // rst rdy be -> dl fl ov own to, outputs sampled just after the edge
      for (int i = 0; i < 5; i++) add(1, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0);
      add(0, 2'b11, 2'b00, 2'b01, 2'b00, 1, 0, 0); // GRANT cam0
      add(0, 2'b11, 2'b00, 2'b00, 2'b00, 1, 0, 0); // WAIT_START
      add(0, 2'b10, 2'b00, 2'b00, 2'b00, 1, 0, 0); // ready0 low -> XFER
      add(0, 2'b10, 2'b01, 2'b00, 2'b00, 1, 0, 0); // empty -> DONE
      add(0, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0); // IDLE, rr_ptr=1
      add(0, 2'b11, 2'b00, 2'b10, 2'b00, 1, 1, 0); // GRANT cam1
      add(0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 1, 0); // WAIT_START
      add(0, 2'b01, 2'b10, 2'b00, 2'b00, 1, 1, 0); // XFER, already empty
      add(0, 2'b01, 2'b10, 2'b00, 2'b00, 1, 1, 0); // DONE after 1 XFER cycle
      add(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 1, 0); // IDLE, rr_ptr=0
      add(0, 2'b11, 2'b00, 2'b01, 2'b00, 1, 0, 0); // GRANT cam0
      add(0, 2'b10, 2'b00, 2'b00, 2'b00, 1, 0, 0);
      add(0, 2'b10, 2'b01, 2'b00, 2'b00, 1, 0, 0);
      add(0, 2'b10, 2'b01, 2'b00, 2'b00, 1, 0, 0); // DONE
      add(0, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0); // IDLE, rr_ptr=1
      add(0, 2'b11, 2'b00, 2'b10, 2'b00, 1, 1, 0); // GRANT cam1, not cam0 again
      add(0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 1, 0);
      add(0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 1, 0); // XFER
      add(0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 1, 0); // still XFER
      add(1, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0); // reset mid-XFER
      add(0, 2'b11, 2'b00, 2'b01, 2'b00, 1, 0, 0); // rr_ptr back to 0 -> cam0

      for (int i = 0; i < vq.size(); i++) begin
         step(vq[i].rst, vq[i].rdy, vq[i].be);
         check($sformatf("vec%0d", i),
               {25'd0, download_pulse, flush_pulse, owner_valid, owner, timeout_evt},
               {25'd0, vq[i].dl, vq[i].fl, vq[i].ov, vq[i].own, vq[i].to});
         if (vq[i].rst) check($sformatf("vec%0d_len", i), {16'd0, last_xfer_len}, 32'd0);
      end

      // Watchdog: cam0 granted, ready held high for 16 WAIT_START cycles.
      for (int k = 1; k <= 16; k++) begin
         step(0, 2'b11, 2'b00);
         check($sformatf("wd_cyc%0d", k),
               {27'd0, download_pulse, flush_pulse, timeout_evt},
               {27'd0, 2'b00, (k == 16) ? 2'b01 : 2'b00, (k == 16) ? 1'b1 : 1'b0});
      end
      for (int k = 0; k < 20; k++) begin
         step(0, 2'b11, 2'b00);
         check($sformatf("xfer_nowd%0d", k),
               {28'd0, flush_pulse, owner_valid, timeout_evt}, {28'd0, 2'b00, 1'b1, 1'b0});
      end
      step(0, 2'b11, 2'b01);
      check("wd_done_valid", {31'd0, owner_valid}, 32'd1);
      step(0, 2'b00, 2'b00);
      check("wd_idle_valid", {31'd0, owner_valid}, 32'd0);

      // Single camera 1: ready drops 2 cycles after the pulse, empty 20 cycles later.
      step(0, 2'b10, 2'b00);
      check("cam1_grant", {29'd0, download_pulse, owner}, {29'd0, 2'b10, 1'b1});
      step(0, 2'b10, 2'b00);
      step(0, 2'b10, 2'b00);
      step(0, 2'b00, 2'b00);
      for (int k = 0; k < 19; k++) step(0, 2'b00, 2'b00);
      check("cam1_xfer_valid", {31'd0, owner_valid}, 32'd1);
      step(0, 2'b00, 2'b10);
      check("cam1_done", {30'd0, owner_valid, owner}, {30'd0, 1'b1, 1'b1});
      check("cam1_len", {16'd0, last_xfer_len}, {16'd0, EXP_LEN});
      step(0, 2'b00, 2'b00);
      check("cam1_idle", {31'd0, owner_valid}, 32'd0);
      check("cam1_len_hold", {16'd0, last_xfer_len}, {16'd0, EXP_LEN});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
